// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: a CPU write of page PP to DMA_REG_ADDR stalls the CPU and copies $PP00-$PPFF to OAM_DATA_ADDR.
// Define OAM_DMA_ALIGN_EN to add the ALIGN state and bus-parity tracking (READs land on even cycles only).
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [7:0]  mem_din,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_dout,
    output logic        dma_we,
    output logic        dma_done
);

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
    typedef enum logic [1:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data;
    logic        trigger;
    logic        last_write;
`ifdef OAM_DMA_ALIGN_EN
    logic        odd;
`endif

    assign trigger    = cpu_we && (cpu_addr == DMA_REG_ADDR);
    assign last_write = (state == WRITE) && (idx == 8'hFF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            page     <= '0;
            idx      <= '0;
            data     <= '0;
            dma_done <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            odd      <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            dma_done <= last_write;
`ifdef OAM_DMA_ALIGN_EN
            odd      <= ~odd;
`endif
            // Triggers outside IDLE are dropped: the CPU is stalled anyway.
            if (state == IDLE && trigger) begin
                page <= cpu_dout;
                idx  <= '0;
            end
            if (state == READ) begin
                data <= mem_din;
            end
            if (state == WRITE && idx != 8'hFF) begin
                idx <= idx + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        dma_addr   = '0;
        dma_dout   = '0;
        dma_we     = 1'b0;
        case (state)
            IDLE: begin
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                if (trigger) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                dma_addr = {page, 8'h00};
`ifdef OAM_DMA_ALIGN_EN
                // odd now means the next cycle is even, which is where READ must sit.
                state_next = odd ? READ : ALIGN;
`else
                state_next = READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
                dma_addr   = {page, 8'h00};
                state_next = READ;
            end
`endif
            READ: begin
                dma_addr   = {page, idx};
                state_next = WRITE;
            end
            WRITE: begin
                dma_addr   = OAM_DATA_ADDR;
                dma_dout   = data;
                dma_we     = 1'b1;
                state_next = (idx == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomised bench for oam_dma_ctrl: a cycle-position model predicts every output each cycle.
module tb_oam_dma_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  mem_din;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_we;
    logic        dma_done;

    logic [7:0]  mem [65536];

    int total = 0;
    int bad   = 0;

    // Model: cycle index since reset release and the position of the current transfer.
    int          cyc    = 0;
    bit          busy   = 1'b0;
    int          t_halt = 0;
    int          extra  = 0;
    logic [7:0]  mpage  = '0;

    int          run = 0;
    int          last_stall = 0;
    int          done_pulses = 0;
    bit          zero_access = 1'b0;
    logic [15:0] last_read = '0;
    logic [7:0]  wq [$];

    oam_dma_ctrl #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_we    (cpu_we),
        .mem_din   (mem_din),
        .cpu_rdy   (cpu_rdy),
        .dma_active(dma_active),
        .dma_addr  (dma_addr),
        .dma_dout  (dma_dout),
        .dma_we    (dma_we),
        .dma_done  (dma_done)
    );

    always #5 clk = ~clk;

    always_comb mem_din = mem[dma_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int xfer_end();
        return t_halt + 1 + extra + 512;
    endfunction

    function automatic bit model_idle(input int k);
        return !busy || (k >= xfer_end());
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            cyc  = 0;
            busy = 1'b0;
        end else begin
            if (cpu_we === 1'b1 && cpu_addr == 16'h4014 && model_idle(cyc)) begin
                busy   = 1'b1;
                t_halt = cyc + 1;
                mpage  = cpu_dout;
`ifdef OAM_DMA_ALIGN_EN
                extra  = (t_halt % 2 == 0) ? 1 : 0;
`else
                extra  = 0;
`endif
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic        e_rdy, e_act, e_we, e_done;
        logic [15:0] e_addr;
        logic [7:0]  e_dout;
        logic [7:0]  i8;
        int p, q;
        e_rdy = 1'b1; e_act = 1'b0; e_we = 1'b0; e_done = 1'b0;
        e_addr = '0; e_dout = '0;
        if (rst && busy) begin
            p = cyc - t_halt;
            q = p - 1 - extra;
            if (p < 1 + extra) begin
                e_rdy = 1'b0; e_act = 1'b1;
                e_addr = {mpage, 8'h00};
            end else if (q < 512) begin
                e_rdy = 1'b0; e_act = 1'b1;
                i8 = 8'(q / 2);
                if (q % 2 == 0) begin
                    e_addr = {mpage, i8};
                end else begin
                    e_addr = 16'h2004;
                    e_dout = mem[{mpage, i8}];
                    e_we   = 1'b1;
                end
            end else if (q == 512) begin
                e_done = 1'b1;
            end
        end
        chk("cpu_rdy", 32'(cpu_rdy), 32'(e_rdy));
        chk("dma_active", 32'(dma_active), 32'(e_act));
        chk("dma_addr", 32'(dma_addr), 32'(e_addr));
        chk("dma_dout", 32'(dma_dout), 32'(e_dout));
        chk("dma_we", 32'(dma_we), 32'(e_we));
        chk("dma_done", 32'(dma_done), 32'(e_done));
`ifdef OAM_DMA_ALIGN_EN
        if (rst && dma_we === 1'b1) chk("write_on_odd", 32'(cyc % 2), 32'd1);
`endif
        if (!rst) begin
            run = 0;
        end else begin
            if (dma_we === 1'b1 && dma_addr == 16'h2004) wq.push_back(dma_dout);
            if (dma_done === 1'b1) done_pulses++;
            if (dma_active === 1'b1 && dma_addr == 16'h0000) zero_access = 1'b1;
            if (dma_active === 1'b1 && dma_we === 1'b0) last_read = dma_addr;
            if (cpu_rdy === 1'b0) begin
                run++;
            end else if (run > 0) begin
                last_stall = run;
                run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_dout = d; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_addr = '0; cpu_dout = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!model_idle(cyc) && n < 700) begin
            tick();
            n++;
        end
        if (n >= 700) chk(name, 32'(n), 32'd0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"},  32'(cpu_rdy),    32'd1);
        chk({tag, "_act"},  32'(dma_active), 32'd0);
        chk({tag, "_addr"}, 32'(dma_addr),   32'd0);
        chk({tag, "_dout"}, 32'(dma_dout),   32'd0);
        chk({tag, "_we"},   32'(dma_we),     32'd0);
        chk({tag, "_done"}, 32'(dma_done),   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs, n;
        cpu_addr = '0; cpu_dout = '0; cpu_we = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;
        repeat (4) tick();

        // Basic copy from page 2
        wq.delete(); done_pulses = 0;
        cpu_write(16'h4014, 8'h02);
        wait_idle("copy_timeout");
        chk("copy_len", 32'(wq.size()), 32'd256);
        errs = 0;
        for (int i = 0; i < 256 && i < wq.size(); i++)
            if (wq[i] !== (8'(i) ^ 8'h5A)) errs++;
        chk("copy_data_errs", 32'(errs), 32'd0);
        chk("copy_done_pulses", 32'(done_pulses), 32'd1);

        // HALT on an odd cycle (trigger in an even one)
        if (cyc % 2 == 1) tick();
        cpu_write(16'h4014, 8'h31);
        wait_idle("odd_timeout");
        chk("stall_odd_halt", 32'(last_stall), 32'd513);

        // HALT on an even cycle
        if (cyc % 2 == 0) tick();
        cpu_write(16'h4014, 8'h47);
        wait_idle("even_timeout");
`ifdef OAM_DMA_ALIGN_EN
        chk("stall_even_halt", 32'(last_stall), 32'd514);
`else
        chk("stall_even_halt", 32'(last_stall), 32'd513);
`endif

        // Page FF boundary
        zero_access = 1'b0;
        cpu_write(16'h4014, 8'hFF);
        wait_idle("ff_timeout");
        chk("ff_no_zero_access", 32'(zero_access), 32'd0);
        chk("ff_last_read", 32'(last_read), 32'hFFFF);
        chk("ff_rdy_back", 32'(cpu_rdy), 32'd1);

        // Ignored writes mid-transfer, then retrigger in the done cycle
        wq.delete();
        cpu_write(16'h4014, 8'h10);
        repeat (50) tick();
        cpu_write(16'h4014, 8'h20);
        repeat (7) tick();
        cpu_write(16'h4014, 8'h21);
        n = 0;
        while (dma_done !== 1'b1 && n < 700) begin
            tick();
            n++;
        end
        chk("b2b_done_seen", 32'(dma_done), 32'd1);
        chk("ignored_first_byte", 32'(wq.size() > 0 ? wq[0] : 8'hxx), 32'(mem[16'h1000]));
        chk("ignored_last_byte", 32'(wq.size() == 256 ? wq[255] : 8'hxx), 32'(mem[16'h10FF]));
        wq.delete();
        cpu_write(16'h4014, 8'h33);
        wait_idle("b2b_timeout");
        chk("b2b_len", 32'(wq.size()), 32'd256);
        chk("b2b_byte7", 32'(wq.size() > 7 ? wq[7] : 8'hxx), 32'(mem[16'h3307]));

        // Random transfers with random CPU bus noise
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 5)) begin
                if ($urandom % 2 == 0) cpu_write(16'($urandom_range(0, 16'h4013)), 8'($urandom));
                else tick();
            end
            cpu_write(16'h4014, 8'($urandom));
            n = 0;
            while (!model_idle(cyc) && n < 700) begin
                if ($urandom % 8 == 0)
                    cpu_write(($urandom % 2 == 0) ? 16'h4014 : 16'($urandom), 8'($urandom));
                else
                    tick();
                n++;
            end
            if (n >= 700) chk("rand_timeout", 32'(n), 32'd0);
            tick();
        end

        // Asynchronous reset mid-transfer, then restart
        cpu_write(16'h4014, 8'h05);
        repeat (100) tick();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) tick();
        wq.delete();
        cpu_write(16'h4014, 8'h05);
        wait_idle("restart_timeout");
        chk("restart_len", 32'(wq.size()), 32'd256);
        chk("restart_byte0", 32'(wq.size() > 0 ? wq[0] : 8'hxx), 32'(mem[16'h0500]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
